// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, FSM state type, S-box and xtime helpers
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic {IDLE, RUN} fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5; 8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0; 8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc; 8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a; 8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0; 8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b; 8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85; 8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5; 8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17; 8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88; 8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c; 8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9; 8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6; 8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e; 8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94; 8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68; 8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES round: SubBytes, ShiftRows, MixColumns (optional), AddRoundKey
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [15:0][7:0] sb;
  logic [15:0][7:0] sr;
  logic [15:0][7:0] mc;

  always_comb begin
    sb = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(state_in[8*i +: 8]);
  end

  // Row r of column c takes the byte from column (c + r) mod 4.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
  end

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  always_comb begin
    state_out = '0;
    for (int i = 0; i < 16; i++)
      state_out[8*i +: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[8*i +: 8];
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES-128 encryptor, one round per clock, start/busy/done handshake
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [127:0]  plaintext,
  input  logic [1407:0] expandedKey,
  output logic          busy,
  output logic          done,
  output logic [127:0]  ciphertext
);

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] ct_q, ct_d;
  logic         done_q, done_d;
  logic [127:0] rk;
  logic [127:0] round_out;
  logic         final_round;

  // Explicit mux keeps unused counter codes from indexing past the key bus.
  always_comb begin
    rk = '0;
    for (int k = 0; k <= NR; k++)
      if (round_q == 4'(k)) rk = expandedKey[128*k +: 128];
  end

  assign final_round = (round_q == 4'(NR));

  aes_round u_round (
    .state_in    (state_q),
    .round_key   (rk),
    .final_round (final_round),
    .state_out   (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = plaintext ^ expandedKey[127:0];
          round_d = 4'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = round_out;
        round_d = round_q + 4'd1;
        if (final_round) begin
          ct_d    = round_out;
          done_d  = 1'b1;
          round_d = 4'd0;
          fsm_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      state_q <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (fsm_q == RUN);
  assign done       = done_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb/tb_aes_encrypt_iter.sv - scoreboard bench for aes_encrypt_iter with FIPS-197 vectors
module tb_aes_encrypt_iter;
  import aes_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [127:0]  plaintext;
  logic [1407:0] expanded_key;
  logic          busy;
  logic          done;
  logic [127:0]  ciphertext;

  aes_encrypt_iter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .plaintext   (plaintext),
    .expandedKey (expanded_key),
    .busy        (busy),
    .done        (done),
    .ciphertext  (ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // FIPS-197 hex strings list byte 0 first; the bus puts byte 0 in [7:0].
  function automatic logic [127:0] fips(input logic [127:0] x);
    logic [127:0] o;
    for (int j = 0; j < 16; j++) o[8*j +: 8] = x[127 - 8*j -: 8];
    return o;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] kbus);
    logic [7:0]    w [0:175];
    logic [7:0]    t [0:3];
    logic [7:0]    tmp;
    logic [7:0]    rcon;
    logic [1407:0] o;
    rcon = 8'h01;
    for (int j = 0; j < 16; j++) w[j] = kbus[8*j +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int b = 0; b < 4; b++) t[b] = w[4*(i-1) + b];
      if (i % 4 == 0) begin
        tmp  = t[0];
        t[0] = sbox(t[1]) ^ rcon;
        t[1] = sbox(t[2]);
        t[2] = sbox(t[3]);
        t[3] = sbox(tmp);
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      for (int b = 0; b < 4; b++) w[4*i + b] = w[4*(i-4) + b] ^ t[b];
    end
    for (int j = 0; j < 176; j++) o[8*j +: 8] = w[j];
    return o;
  endfunction

  logic [127:0]  pt_b, ct_b, pt_c, ct_c;
  logic [1407:0] ek_b, ek_c;

  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    exp_busy = (q.size() != 0) && (cyc != q[0].due);
    check("busy", {127'd0, busy}, {127'd0, exp_busy});
    if (done) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("done_cycle", 128'(cyc), 128'(e.due));
        check("ciphertext", ciphertext, e.ct);
      end
    end else if (q.size() != 0 && cyc >= q[0].due) begin
      e = q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_done: got done=0 expected done=1 (cycle %0d)", cyc);
    end
  end

  task automatic accept(input logic [127:0] pt, input logic [1407:0] ek, input logic [127:0] ct);
    plaintext    = pt;
    expanded_key = ek;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    q.push_back('{ct: ct, due: cyc + 10});
  endtask

  initial begin
    pt_b = fips(128'h3243f6a8885a308d313198a2e0370734);
    ct_b = fips(128'h3925841d02dc09fbdc118597196a0b32);
    ek_b = expand(fips(128'h2b7e151628aed2a6abf7158809cf4f3c));
    pt_c = fips(128'h00112233445566778899aabbccddeeff);
    ct_c = fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    ek_c = expand(fips(128'h000102030405060708090a0b0c0d0e0f));

    rst_n = 1'b0; start = 1'b0; plaintext = '0; expanded_key = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ct", ciphertext, 128'd0);
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_done", {127'd0, done}, 128'd0);

    // start coinciding with reset must not launch a run
    plaintext = pt_b; expanded_key = ek_b; start = 1'b1;
    @(posedge clk); #1;
    check("start_in_reset_busy", {127'd0, busy}, 128'd0);
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // App. B with start pulses during RUN and plaintext disturbed after acceptance
    accept(pt_b, ek_b, ct_b);
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    accept(pt_c, ek_c, ct_c);
    repeat (11) @(posedge clk);
    #1;

    // start held: accepted at E0, E11, E22, E33
    plaintext = pt_c; expanded_key = ek_c; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i % 11 == 0) q.push_back('{ct: ct_c, due: cyc + 10});
    end
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;

    // reset at E5 aborts the run
    accept(pt_b, ek_b, ct_b);
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    rst_n = 1'b1;
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_done", {127'd0, done}, 128'd0);
    check("abort_ct", ciphertext, 128'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_ct_held", ciphertext, 128'd0);
    accept(pt_b, ek_b, ct_b);
    repeat (12) @(posedge clk);
    #1;
    check("final_ct_held", ciphertext, ct_b);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_encrypt_iter.md
# aes_encrypt_iter

Iterative AES-128 encryption core, one round per clock. Sits directly downstream of the key-expansion stage and consumes its 1408-bit round-key bus. Takes a 128-bit plaintext block and produces the ciphertext after 10 round cycles, with a start/busy/done handshake.

## Interface
- No parameters. NR = 10 is fixed in the shared package.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request to encrypt `plaintext`. Sampled only in IDLE.
- `plaintext`  in  128  input block. Byte n occupies [8n+7:8n]. State byte index = row + 4·column.
- `expandedKey`  in  1408  round key k occupies [128k+127:128k], k = 0..10. Round key 0 is the cipher key. Byte order matches `plaintext`.
- `busy`  out  1  high while rounds are in progress.
- `done`  out  1  one-cycle pulse when `ciphertext` becomes valid.
- `ciphertext`  out  128  result. Held until the next completion or reset.

## Operation
- FSM states: IDLE, RUN.
  - IDLE → RUN on `start`=1. On that edge: `state_reg` ← `plaintext` ^ rk0, `round` ← 1.
  - RUN, `round` 1..9: `state_reg` ← MixColumns(ShiftRows(SubBytes(s))) ^ rk[round], then `round`++.
  - RUN, `round` = 10: final round without MixColumns. On that edge: result → `ciphertext`, `done` ← 1, `busy` ← 0, FSM → IDLE.
- `round` is a 4-bit counter. Values 0 and 11..15 are never reached in RUN. The rk select is `expandedKey[128·round +: 128]`.
- `start` during RUN is ignored; it is neither queued nor an error.
- `plaintext` is captured at acceptance. `expandedKey` is not latched: it must stay stable from the accepting edge through the round-10 edge. Upstream holds the key constant while `busy`.
- MixColumns uses xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00). All arithmetic is GF(2^8); there is no carry and no width growth.
- ShiftRows: row r rotates left by r columns, so output byte r+4c = input byte r+4((c+r) mod 4).

## Timing
- Reset (`rst_n`=0 at an edge): FSM → IDLE, `busy`=0, `done`=0, `ciphertext`=0, `round`=0, `state_reg`=0.
- Reset mid-RUN aborts the operation: no `done` pulse, and `ciphertext` clears to 0.
- Latency: `start` sampled at edge E0; `busy`=1 after E0; `done`=1 and `ciphertext` valid after E10. That is 10 cycles from acceptance to result.
- `done` is high for exactly one cycle after E10 and low after E11 unless another operation completes.
- Back-to-back: `start` high during the `done` cycle is accepted at E11. Throughput is one block per 11 cycles when `start` is held high.
- `busy` and `done` are never high in the same cycle.
- `ciphertext` changes only on a round-10 edge or on reset.
- `start` and `rst_n`=0 at the same edge: reset wins.

## Structure
- Package `aes_pkg`:
  - `sbox` function (256-entry case).
  - `xtime` function.
  - Constant NR = 10.
  - FSM state enum {IDLE, RUN}.
- Sub-module `aes_round`, purely combinational:
  - Inputs: `state_in`[127:0], `round_key`[127:0], `final_round`.
  - Output: `state_out`[127:0].
  - Applies SubBytes, ShiftRows, MixColumns (bypassed when `final_round`), then AddRoundKey.
  - Instantiated once in this block; the FSM, counter and registers live in `aes_encrypt_iter`.

## Test plan
Hex strings below are FIPS-197 byte order. The first listed byte maps to bits [7:0] of each bus.
- FIPS-197 App. B, checked against a reference model for all 11 round keys: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → after E10, ct 3925841d02dc09fbdc118597196a0b32, `done` pulse exactly 1 cycle.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- `start` held high for 40 cycles with the C.1 vectors → `done` at E10, E21, E32; `busy` low only in the `done` cycles; ct identical each time.
- `start` pulsed at E3 and E7 during RUN, and `plaintext` changed after E0 → ignored; the App. B ct still appears at E10.
- `rst_n`=0 at E5 of a run → after E5 `busy`=0, `done`=0, `ciphertext`=0; no `done` at E10; a new `start` afterwards yields the correct ct 10 cycles later.
- Reset values checked before the first `start`: all outputs 0; `start` and `rst_n`=0 at the same edge → remains IDLE.
